// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   state encoding for the controller FSM, operand/product widths and the
//   last value of the bit counter.
package seq_mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic [2:0] COUNT_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_adder.sv
// adder_Sixteen_bit
// 16-bit ripple-carry adder used as the accumulate stage of the multiplier.
// Ports:
//   dataa, datab : 16-bit addends
//   sum          : 16-bit sum
//   cout         : carry out of bit 15
module adder_Sixteen_bit (
    input  logic [15:0] dataa,
    input  logic [15:0] datab,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry;

    // One full-adder cell per bit, carry rippling from bit 0 upward.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sum[i]     = dataa[i] ^ datab[i] ^ carry[i];
            carry[i+1] = (dataa[i] & datab[i]) | (carry[i] & (dataa[i] ^ datab[i]));
        end
        cout = carry[16];
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
// Sequential 8x8 unsigned shift-and-add multiplier with an IDLE/RUN/DONE
// controller. One multiplier bit is consumed per clock in RUN.
// Parameters:
//   ZERO_SKIP : 1 = finish as soon as the remaining multiplier bits are zero
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : begin a multiply (only looked at in IDLE)
//   dataa    : multiplicand, captured when start is accepted
//   datab    : multiplier, captured when start is accepted
//   product  : registered result, held between operations
//   done     : one-cycle pulse when product has just been updated
//   busy     : high while in RUN or DONE
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    output logic [PROD_W-1:0] product,
    output logic              done,
    output logic              busy
);

    state_t              state;
    state_t              state_next;
    logic [PROD_W-1:0]   mcand;
    logic [OP_W-1:0]     mplier;
    logic [PROD_W-1:0]   acc;
    logic [2:0]          count;
    logic [PROD_W-1:0]   sum;
    logic [PROD_W-1:0]   acc_next;
    logic                finish;
    logic                cout_unused;

    // The carry out is never needed: 255*255 still fits in 16 bits.
    adder_Sixteen_bit u_adder (
        .dataa (acc),
        .datab (mcand),
        .sum   (sum),
        .cout  (cout_unused)
    );

    assign busy = (state != IDLE);

    // Next-state logic. With ZERO_SKIP a multiplier of 0 or 1 still spends
    // one RUN cycle, so done never appears sooner than one edge after accept.
    always_comb begin
        state_next = state;
        acc_next   = mplier[0] ? sum : acc;
        finish     = (count == COUNT_LAST) ||
                     (ZERO_SKIP && ((mplier >> 1) == '0));
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, counter and datapath registers. product is written only on the
    // edge that enters DONE, so it keeps the old result throughout RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{(PROD_W-OP_W){1'b0}}, dataa};
                        mplier <= datab;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 3'd1;
                    if (finish) begin
                        product <= acc_next;
                        done    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
